// File: rtl/sha256_padder_if.sv
// Handshake bundle between a message source, the SHA-256 padder and the compression core.
// The slave modport is the padder's view; the master modport is the source/sink view.
interface sha256_padder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a stream of big-endian message words into padded
// 512-bit blocks (0x80 marker, zero fill, 64-bit bit length) one 32-bit word at a time.
module sha256_padder (
    input  logic            clk,
    input  logic            rst_n,
    sha256_padder_if.slave  bus
);

    typedef enum logic [2:0] {DATA, PAD80, ZERO, LENHI, LENLO} state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic [3:0]  widx_q, widx_d;
    logic [60:0] byte_cnt_q, byte_cnt_d;

    logic        free;
    logic [2:0]  nbytes;
    logic [31:0] data_word;
    logic        load;
    logic [31:0] word;
    logic        word_last;
    state_e      pad_next;

    assign free         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst_n && (state_q == DATA) && free;

    // Non-final words always carry four bytes, whatever in_nbytes says.
    assign nbytes   = (bus.in_last && (bus.in_nbytes < 3'd4)) ? bus.in_nbytes : 3'd4;

    // The length words must land at indices 14 and 15, so after a padding
    // word at index 13 skip straight to the length; otherwise keep zero-filling.
    assign pad_next = (widx_q == 4'd13) ? LENHI : ZERO;

    always_comb begin
        unique case (nbytes)
            3'd0:    data_word = 32'h8000_0000;
            3'd1:    data_word = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    data_word = {bus.in_data[31:16], 16'h8000};
            3'd3:    data_word = {bus.in_data[31:8], 8'h80};
            default: data_word = bus.in_data;
        endcase
    end

    // NOTE: every signal written in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        out_valid_d = free ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q && !free;
        widx_d      = widx_q;
        byte_cnt_d  = byte_cnt_q;
        load        = 1'b0;
        word        = 32'h0;
        word_last   = 1'b0;

        if (free) begin
            unique case (state_q)
                DATA: begin
                    if (bus.in_valid) begin
                        load       = 1'b1;
                        word       = data_word;
                        byte_cnt_d = byte_cnt_q + 61'(nbytes);
                        if (bus.in_last) begin
                            state_d = (nbytes == 3'd4) ? PAD80 : pad_next;
                        end
                    end
                end
                PAD80: begin
                    load    = 1'b1;
                    word    = 32'h8000_0000;
                    state_d = pad_next;
                end
                ZERO: begin
                    load    = 1'b1;
                    state_d = pad_next;
                end
                LENHI: begin
                    load    = 1'b1;
                    word    = byte_cnt_q[60:29];
                    state_d = LENLO;
                end
                LENLO: begin
                    load       = 1'b1;
                    word       = {byte_cnt_q[28:0], 3'b000};
                    word_last  = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = DATA;
                end
                default: state_d = DATA;
            endcase
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_idx_d   = widx_q;
            out_last_d  = word_last;
            widx_d      = widx_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DATA;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
            widx_q      <= 4'd0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            widx_q      <= widx_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: a byte-level padding model fills a scoreboard,
// and a monitor compares every transferred output word against it.
module tb_sha256_padder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] msg[$];
    logic [3:0] exp_idx = 4'd0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Reference padding on bytes: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nw;
        exp_t        e;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) << 3;
        for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.data  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.idx   = exp_idx;
            e.last  = (w == nw - 1);
            sb_q.push_back(e);
            exp_idx = exp_idx + 4'd1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_word: observed %0h expected none", bus.out_data);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.data));
                check("out_idx", 64'(bus.out_idx), 64'(e.idx));
                check("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                check("latency_out_valid", 64'(bus.out_valid), 64'd1);
                break;
            end
            n++;
            if (n > 100) begin
                fail_now("accept_timeout");
                break;
            end
        end
    endtask

    task automatic do_stall();
        logic [31:0] held_data;
        logic [3:0]  held_idx;
        bus.out_ready = 1'b0;
        held_data = bus.out_data;
        held_idx  = bus.out_idx;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_data", 64'(bus.out_data), 64'(held_data));
            check("stall_out_idx", 64'(bus.out_idx), 64'(held_idx));
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
    endtask

    task automatic send_msg(input int stall_word);
        int          nwords;
        int          nb;
        logic [31:0] d;
        push_expected();
        nwords = (msg.size() + 3) / 4;
        if (nwords == 0) nwords = 1;
        for (int w = 0; w < nwords; w++) begin
            d  = 32'h0;
            nb = msg.size() - 4 * w;
            if (nb > 4) nb = 4;
            for (int b = 0; b < nb; b++) d[31 - 8*b -: 8] = msg[4*w + b];
            bus.in_data   = d;
            bus.in_last   = (w == nwords - 1);
            bus.in_nbytes = bus.in_last ? 3'(nb) : 3'($urandom_range(0, 7));
            bus.in_valid  = 1'b1;
            if (w == stall_word) do_stall();
            wait_accept();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                sb_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input int len, input int seed);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(i * 7 + seed));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = 3'd0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_idx", 64'(bus.out_idx), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(-1);
        wait_drain();

        // Empty message
        msg.delete();
        send_msg(-1);
        wait_drain();

        // 56 bytes: pad lands at index 14, forcing a second block
        set_msg(56, 1);
        send_msg(-1);
        wait_drain();

        // 55 bytes: pad shares the word at index 13
        set_msg(55, 3);
        send_msg(-1);
        wait_drain();

        // 60 bytes: pad at index 15, extra block
        set_msg(60, 5);
        send_msg(-1);
        wait_drain();

        // Back-to-back short messages, 1 and 6 bytes
        set_msg(1, 9);
        send_msg(-1);
        set_msg(6, 11);
        send_msg(-1);
        wait_drain();

        // Backpressure for 5 cycles mid-message
        set_msg(22, 13);
        send_msg(3);
        wait_drain();

        // Reset while zero-filling, then "abc" again from a clean state
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(-1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_out_idx", 64'(bus.out_idx), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        sb_q.delete();
        exp_idx = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(-1);
        wait_drain();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  upstream message word valid.
REQ-004 in_ready  output  1  padder accepts in_data this cycle.
REQ-005 in_data  input  32  message word, big-endian; first byte in [31:24].
REQ-006 in_last  input  1  word is the final word of the message.
REQ-007 in_nbytes  input  3  valid bytes in a last word, 0..4; ignored and taken as 4 when in_last=0.
REQ-008 out_valid  output  1  out_data holds a block word.
REQ-009 out_ready  input  1  downstream (compression core) accepts the word.
REQ-010 out_data  output  32  padded block word W[out_idx].
REQ-011 out_idx  output  4  word index within the 512-bit block, 0..15.
REQ-012 out_last  output  1  word is W[15] of the final block of the message.

Function
REQ-013 Transfers occur on valid&ready at the rising edge; out_data, out_idx and out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-014 Output register free = !out_valid | out_ready; in_ready = (state==DATA) & free, combinational, and 0 while rst_n=0.
REQ-015 Latency: an accepted input word appears on out_data in the next cycle.
REQ-016 States: DATA, PAD80, ZERO, LENHI, LENLO; each generated word loads only when the output register is free.
REQ-017 DATA, in_last=0: out_data=in_data; byte counter += 4.
REQ-018 DATA, in_last=1, n=in_nbytes: byte counter += n.
- n<4: out_data = the top n bytes of in_data, then 0x80 in byte n, zeros below; next state ZERO.
- n=4: out_data=in_data; next state PAD80.
REQ-019 PAD80 emits 0x80000000, then goes to ZERO.
REQ-020 ZERO emits 0x00000000 until the word just emitted has index 13, then goes to LENHI.
- If the pad word fell at index 14 or 15, ZERO continues through index 15, wraps to 0, and runs to index 13 of an extra block.
REQ-021 LENHI emits bits [63:32] of the message bit length; LENLO emits bits [31:0] with out_last=1.
- Then: byte counter cleared; state returns to DATA.
REQ-022 Arithmetic: byte counter is 61 bits and wraps modulo 2^61; bit length = {byte_cnt, 3'b000}.
- out_idx increments per emitted word, wrapping 15->0.
REQ-023 in_valid during non-DATA states SHALL be ignored (in_ready=0); no input word is dropped or duplicated under backpressure.
REQ-024 out_last is 1 on no word other than the LENLO word.

Reset
REQ-025 rst_n=0 asynchronously forces the following, regardless of state or handshakes in flight:
- state=DATA
- out_valid=0, out_data=0, out_idx=0, out_last=0
- byte counter=0
REQ-026 After release, the first accepted word is emitted with out_idx=0; a partial message in progress at reset is discarded.

Verification
REQ-027 "abc": in_data=0x61626300, in_last=1, in_nbytes=3 -> 16 words: idx0=0x61626380, idx1..14=0, idx15=0x00000018 with out_last=1.
REQ-028 Empty message: in_last=1, in_nbytes=0 -> idx0=0x80000000, idx1..15=0, out_last at idx15.
REQ-029 56 bytes (14 full words, last in_nbytes=4) -> idx14=0x80000000, idx15=0, then a second block: idx0..14=0, idx15=0x000001C0; out_last only on the second idx15.
REQ-030 55 bytes (last word at idx13, in_nbytes=3) -> idx13 = the top three data bytes followed by 0x80, idx14=0, idx15=0x000001B8; single block.
REQ-031 out_ready=0 for 5 cycles mid-message -> out_data/out_idx stable, in_ready=0, and the word sequence is identical to the no-stall run.
REQ-032 rst_n pulsed low during ZERO state -> out_valid=0 immediately; the next message "abc" yields the REQ-027 sequence exactly.
